// File: rtl/fruit_split_launcher.sv
// Launch controller for the two fruit-half motion stages: splits a slice event into
// left/right half initial values and holds Initialize for exactly one frame edge.
// Optional build macro SPLIT_JITTER_EN adds LFSR-driven +/-1 X-velocity jitter.
module fruit_split_launcher #(
   parameter int DATA_W            = 32,
   parameter int SPLIT_OFFSET      = 8,
   parameter int SPLIT_DX          = 2,
   parameter int POP_DY            = 3,
   parameter int V_MAX             = 12,
   parameter int MIN_FLIGHT_FRAMES = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     frame_clk_rising_edge,
   input  logic                     slice_req,
   input  logic signed [DATA_W-1:0] fruit_x,
   input  logic signed [DATA_W-1:0] fruit_y,
   input  logic signed [DATA_W-1:0] fruit_vx,
   input  logic signed [DATA_W-1:0] fruit_vy,
   input  logic                     h1_out_of_screen,
   input  logic                     h2_out_of_screen,
   output logic                     slice_ack,
   output logic                     busy,
   output logic                     h1_init,
   output logic                     h2_init,
   output logic signed [DATA_W-1:0] h1_x,
   output logic signed [DATA_W-1:0] h1_y,
   output logic signed [DATA_W-1:0] h1_vx,
   output logic signed [DATA_W-1:0] h1_vy,
   output logic signed [DATA_W-1:0] h2_x,
   output logic signed [DATA_W-1:0] h2_y,
   output logic signed [DATA_W-1:0] h2_vx,
   output logic signed [DATA_W-1:0] h2_vy,
   output logic [7:0]               drop_count
);

   localparam int CNT_W = $clog2(MIN_FLIGHT_FRAMES + 1);
   localparam logic [CNT_W-1:0]         FR_MAX = CNT_W'(MIN_FLIGHT_FRAMES);
   localparam logic signed [DATA_W-1:0] OFF_S  = DATA_W'(SPLIT_OFFSET);
   localparam logic signed [DATA_W-1:0] DX_S   = DATA_W'(SPLIT_DX);
   localparam logic signed [DATA_W-1:0] DY_S   = DATA_W'(POP_DY);
   localparam logic signed [DATA_W-1:0] VMAX_S = DATA_W'(V_MAX);
   localparam logic signed [DATA_W-1:0] VMIN_S = -VMAX_S;

   typedef enum logic [1:0] {IDLE, ARMED, FLY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   frames_q;
   logic signed [DATA_W-1:0] jit_p0;
   logic signed [DATA_W-1:0] h1_vx_p0, h2_vx_p0, hv_vy_p0;

   function automatic logic signed [DATA_W-1:0] clamp_v(input logic signed [DATA_W-1:0] v);
      if (v > VMAX_S)      return VMAX_S;
      else if (v < VMIN_S) return VMIN_S;
      else                 return v;
   endfunction

`ifdef SPLIT_JITTER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge Clk) begin
      if (Reset)
         lfsr_q <= 16'hACE1;
      else if (frame_clk_rising_edge)
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_comb begin
      jit_p0 = '0;
      case (lfsr_q[1:0])
         2'b00:   jit_p0 = -DATA_W'(1);
         2'b11:   jit_p0 = DATA_W'(1);
         default: jit_p0 = '0;
      endcase
   end
`else
   assign jit_p0 = '0;
`endif

   // p0: launch values computed combinationally from the slice event
   assign h1_vx_p0 = clamp_v(fruit_vx - DX_S + jit_p0);
   assign h2_vx_p0 = clamp_v(fruit_vx + DX_S - jit_p0);
   assign hv_vy_p0 = clamp_v(fruit_vy - DY_S);

   always_comb begin
      state_d   = state_q;
      slice_ack = 1'b0;
      busy      = (state_q != IDLE);
      h1_init   = (state_q == ARMED);
      h2_init   = (state_q == ARMED);
      case (state_q)
         IDLE: begin
            slice_ack = slice_req && !Reset;
            if (slice_req) state_d = ARMED;
         end
         ARMED: if (frame_clk_rising_edge) state_d = FLY;
         FLY: if (frames_q == FR_MAX && h1_out_of_screen && h2_out_of_screen) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // p1: registered launch values, flight counter and drop counter
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         frames_q   <= '0;
         drop_count <= '0;
         h1_x <= '0; h1_y <= '0; h1_vx <= '0; h1_vy <= '0;
         h2_x <= '0; h2_y <= '0; h2_vx <= '0; h2_vy <= '0;
      end else begin
         state_q <= state_d;
         if (slice_ack) begin
            h1_x  <= fruit_x - OFF_S;
            h2_x  <= fruit_x + OFF_S;
            h1_y  <= fruit_y;
            h2_y  <= fruit_y;
            h1_vx <= h1_vx_p0;
            h2_vx <= h2_vx_p0;
            h1_vy <= hv_vy_p0;
            h2_vy <= hv_vy_p0;
         end
         if (slice_req && state_q != IDLE && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         // A stale out_of_screen cannot end the flight until enough frames have passed
         if (state_q == ARMED && frame_clk_rising_edge)
            frames_q <= '0;
         else if (state_q == FLY && frame_clk_rising_edge && frames_q != FR_MAX)
            frames_q <= frames_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fruit_split_launcher.sv
// Directed bench for fruit_split_launcher with a flight-level reference model and
// per-cycle output comparison.
module tb_fruit_split_launcher;

   localparam int OFF = 8, DX = 2, DY = 3, VM = 12, MINF = 4;

   logic Clk, Reset, frame_clk_rising_edge, slice_req;
   logic signed [31:0] fruit_x, fruit_y, fruit_vx, fruit_vy;
   logic h1_out_of_screen, h2_out_of_screen;
   logic slice_ack, busy, h1_init, h2_init;
   logic signed [31:0] h1_x, h1_y, h1_vx, h1_vy, h2_x, h2_y, h2_vx, h2_vy;
   logic [7:0] drop_count;

   int total = 0;
   int bad   = 0;

   fruit_split_launcher dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
      .slice_req(slice_req), .fruit_x(fruit_x), .fruit_y(fruit_y),
      .fruit_vx(fruit_vx), .fruit_vy(fruit_vy),
      .h1_out_of_screen(h1_out_of_screen), .h2_out_of_screen(h2_out_of_screen),
      .slice_ack(slice_ack), .busy(busy), .h1_init(h1_init), .h2_init(h2_init),
      .h1_x(h1_x), .h1_y(h1_y), .h1_vx(h1_vx), .h1_vy(h1_vy),
      .h2_x(h2_x), .h2_y(h2_y), .h2_vx(h2_vx), .h2_vy(h2_vy),
      .drop_count(drop_count)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > VM) ? VM : (v < -VM) ? -VM : v;
   endfunction

   // Reference model: flight phase (0 idle, 1 waiting for frame edge, 2 flying)
   int m_phase = 0, m_frames = 0, m_drops = 0;
   int m_h1x = 0, m_h1y = 0, m_h1vx = 0, m_h1vy = 0;
   int m_h2x = 0, m_h2y = 0, m_h2vx = 0, m_h2vy = 0;
   bit m_valid = 0;
   logic [15:0] m_lfsr = 16'hACE1;

   function automatic int jitter(input logic [15:0] l);
`ifdef SPLIT_JITTER_EN
      if (l[1:0] == 2'b00) return -1;
      if (l[1:0] == 2'b11) return 1;
`endif
      return 0;
   endfunction

   always @(posedge Clk) begin
      int p, j;
      if (Reset) begin
         m_phase = 0; m_frames = 0; m_drops = 0; m_valid = 1;
         m_h1x = 0; m_h1y = 0; m_h1vx = 0; m_h1vy = 0;
         m_h2x = 0; m_h2y = 0; m_h2vx = 0; m_h2vy = 0;
         m_lfsr = 16'hACE1;
      end else begin
         p = m_phase;
         if (slice_req) begin
            if (p == 0) begin
               j = jitter(m_lfsr);
               m_h1x = fruit_x - OFF;  m_h2x = fruit_x + OFF;
               m_h1y = fruit_y;        m_h2y = fruit_y;
               m_h1vx = clampv(fruit_vx - DX + j);
               m_h2vx = clampv(fruit_vx + DX - j);
               m_h1vy = clampv(fruit_vy - DY);
               m_h2vy = m_h1vy;
               m_phase = 1;
            end else if (m_drops < 255) m_drops++;
         end
         if (p == 1 && frame_clk_rising_edge) begin
            m_phase = 2; m_frames = 0;
         end
         if (p == 2) begin
            if (m_frames == MINF && h1_out_of_screen && h2_out_of_screen) m_phase = 0;
            if (frame_clk_rising_edge && m_frames < MINF) m_frames++;
         end
         if (frame_clk_rising_edge)
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         chk("m_ack",  int'(slice_ack), int'(m_phase == 0 && slice_req && !Reset));
         chk("m_busy", int'(busy), int'(m_phase != 0));
         chk("m_init1", int'(h1_init), int'(m_phase == 1));
         chk("m_init2", int'(h2_init), int'(m_phase == 1));
         chk("m_h1_x", h1_x, m_h1x);   chk("m_h1_y", h1_y, m_h1y);
         chk("m_h1_vx", h1_vx, m_h1vx); chk("m_h1_vy", h1_vy, m_h1vy);
         chk("m_h2_x", h2_x, m_h2x);   chk("m_h2_y", h2_y, m_h2y);
         chk("m_h2_vx", h2_vx, m_h2vx); chk("m_h2_vy", h2_vy, m_h2vy);
         chk("m_drops", int'(drop_count), m_drops);
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_fruit(input int x, input int y, input int vx, input int vy);
      fruit_x = x; fruit_y = y; fruit_vx = vx; fruit_vy = vy;
   endtask

   initial begin
      Reset = 1; frame_clk_rising_edge = 0; slice_req = 0;
      h1_out_of_screen = 0; h2_out_of_screen = 0;
      set_fruit(0, 0, 0, 0);
      cyc(); cyc();
      @(negedge Clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_init", int'(h1_init), 0);
      chk("rst_drop", int'(drop_count), 0);
      chk("rst_h1x", h1_x, 0);

      // Basic launch
      cyc();
      Reset = 0;
      cyc();
      set_fruit(320, 200, 3, -5);
      slice_req = 1;
      @(negedge Clk);
      chk("t1_ack", int'(slice_ack), 1);
      cyc();
      slice_req = 0;
      @(negedge Clk);
      chk("t1_h1x", h1_x, 312);  chk("t1_h1y", h1_y, 200);
      chk("t1_h1vx", h1_vx, 1);  chk("t1_h1vy", h1_vy, -8);
      chk("t1_h2x", h2_x, 328);  chk("t1_h2y", h2_y, 200);
      chk("t1_h2vx", h2_vx, 5);  chk("t1_h2vy", h2_vy, -8);
      chk("t1_busy", int'(busy), 1);
      chk("t1_init", int'(h1_init), 1);

      // Single frame edge consumed by ARMED
      repeat (4) cyc();
      frame_clk_rising_edge = 1;
      @(negedge Clk);
      chk("t2_init_edge", int'(h2_init), 1);
      cyc();
      frame_clk_rising_edge = 0;
      @(negedge Clk);
      chk("t2_init_after", int'(h1_init), 0);
      chk("t2_busy_fly", int'(busy), 1);

      // Only h1 out: flight never ends
      h1_out_of_screen = 1;
      repeat (6) begin
         frame_clk_rising_edge = 1; cyc();
         frame_clk_rising_edge = 0; cyc();
      end
      @(negedge Clk);
      chk("t4_h1only_busy", int'(busy), 1);
      h2_out_of_screen = 1;
      cyc();
      @(negedge Clk);
      chk("t4_end_busy", int'(busy), 0);

      // Clamped launch, stale out_of_screen still high
      cyc();
      set_fruit(100, 50, 11, -11);
      slice_req = 1;
      @(negedge Clk);
      chk("t3_ack", int'(slice_ack), 1);
      cyc();
      slice_req = 0;
      @(negedge Clk);
      chk("t3_h1x", h1_x, 92);
      chk("t3_h1vy", h1_vy, -12);
      chk("t3_h2vy", h2_vy, -12);
`ifndef SPLIT_JITTER_EN
      chk("t3_h2vx", h2_vx, 12);
      chk("t3_h1vx", h1_vx, 9);
`endif

      // Requests while busy are dropped
      cyc();
      slice_req = 1;
      repeat (3) begin
         @(negedge Clk);
         chk("t5_noack", int'(slice_ack), 0);
         cyc();
      end
      slice_req = 0;
      @(negedge Clk);
      chk("t5_drop3", int'(drop_count), 3);

      // Flight ends only after the 4th frame edge
      cyc();
      frame_clk_rising_edge = 1; cyc();
      frame_clk_rising_edge = 0;
      for (int k = 1; k <= 4; k++) begin
         frame_clk_rising_edge = 1; cyc();
         frame_clk_rising_edge = 0;
         @(negedge Clk);
         chk("t4_busy_hold", int'(busy), 1);
         cyc();
         @(negedge Clk);
         chk("t4_busy_edge", int'(busy), (k < 4) ? 1 : 0);
      end

      // Drop counter saturation
      cyc();
      set_fruit(10, 20, 0, 0);
      slice_req = 1;
      @(negedge Clk);
      chk("t5_ack", int'(slice_ack), 1);
      repeat (301) cyc();
      slice_req = 0;
      @(negedge Clk);
      chk("t5_drop_sat", int'(drop_count), 255);

      // Reset while ARMED with a coincident frame edge
      cyc();
      Reset = 1; frame_clk_rising_edge = 1;
      cyc();
      Reset = 0; frame_clk_rising_edge = 0;
      @(negedge Clk);
      chk("t6_init", int'(h1_init), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_h1x", h1_x, 0);
      chk("t6_h2vy", h2_vy, 0);
      chk("t6_drop", int'(drop_count), 0);

      // Reset with a simultaneous request
      cyc();
      Reset = 1; slice_req = 1;
      @(negedge Clk);
      chk("t6_rst_noack", int'(slice_ack), 0);
      cyc();
      Reset = 0; slice_req = 0;
      @(negedge Clk);
      chk("t6_rst_idle", int'(busy), 0);
      chk("t6_rst_nodrop", int'(drop_count), 0);

      // Normal launch after reset
      cyc();
      set_fruit(320, 200, 3, -5);
      slice_req = 1;
      @(negedge Clk);
      chk("t6_ack", int'(slice_ack), 1);
      cyc();
      slice_req = 0;
      @(negedge Clk);
      chk("t6_h2x", h2_x, 328);
      chk("t6_busy2", int'(busy), 1);
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
